// File: rtl/psu_uc_sequencer.sv
// rtl/psu_uc_sequencer.sv - unit-cell step sequencer: walks all unit cells NUM_UCC at a time per instruction
module psu_uc_sequencer #(
    parameter int OPCODE_BW = 4,
    parameter int NUM_UCC   = 4,
    parameter int NUM_UCROW = 4,
    parameter int NUM_UCCOL = 4,
    parameter int UCADDR_BW = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inst_valid,
    input  logic [OPCODE_BW-1:0]          inst_opcode,
    output logic                          inst_ready,
    input  logic                          step_en,
    input  logic                          flush,
    output logic [OPCODE_BW-1:0]          opcode_running,
    output logic [NUM_UCC*UCADDR_BW-1:0]  uc_counter,
    output logic [NUM_UCC-1:0]            uc_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int TOTAL  = NUM_UCROW * NUM_UCCOL;
    // Wide enough for the largest index of the last step, which may overshoot TOTAL.
    localparam int IDX_BW = (TOTAL + NUM_UCC > 2) ? $clog2(TOTAL + NUM_UCC) : 1;
    localparam logic [IDX_BW-1:0] UCC_W   = IDX_BW'(NUM_UCC);
    localparam logic [IDX_BW-1:0] TOTAL_W = IDX_BW'(TOTAL);
    localparam logic [IDX_BW-1:0] ONE_W   = IDX_BW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_BW-1:0]     k_q, k_d;
    logic [OPCODE_BW-1:0]  opcode_q, opcode_d;
    logic [IDX_BW-1:0]     base;
    logic [IDX_BW-1:0]     idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE: begin
                // flush in IDLE only suppresses acceptance
                if (!flush && inst_valid) begin
                    state_d  = S_RUN;
                    k_d      = '0;
                    opcode_d = inst_opcode;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d  = S_IDLE;
                    k_d      = '0;
                    opcode_d = '0;
                end else if (step_en) begin
                    if ((k_q + ONE_W) * UCC_W >= TOTAL_W) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = k_q + ONE_W;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                k_d      = '0;
                opcode_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                k_d      = '0;
                opcode_d = '0;
            end
        endcase
    end

    always_comb begin
        uc_counter = '0;
        uc_valid   = '0;
        idx        = '0;
        base       = k_q * UCC_W;
        if (state_q == S_RUN) begin
            for (int j = 0; j < NUM_UCC; j++) begin
                idx = base + IDX_BW'(j);
                if (idx < TOTAL_W) begin
                    uc_valid[j]                           = 1'b1;
                    uc_counter[j*UCADDR_BW +: UCADDR_BW]  = UCADDR_BW'(idx);
                end
            end
        end
    end

    assign opcode_running = opcode_q;
    assign inst_ready     = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_psu_uc_sequencer.sv
// tb/tb_psu_uc_sequencer.sv - self-checking bench for psu_uc_sequencer
module tb_psu_uc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv = 0, st = 0, fl = 0;
    logic [3:0]  iop = 0;
    logic        ready, busy, done;
    logic [3:0]  op_run;
    logic [15:0] ucc;
    logic [3:0]  ucv;

    logic        iv3 = 0, st3 = 0, fl3 = 0;
    logic [3:0]  iop3 = 0;
    logic        ready3, busy3, done3;
    logic [3:0]  op3;
    logic [11:0] ucc3;
    logic [2:0]  ucv3;

    int checks = 0;
    int errors = 0;

    int         m_phase;
    int         m_k;
    logic [3:0] m_op;

    always #5 clk = ~clk;

    psu_uc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(iv), .inst_opcode(iop), .inst_ready(ready),
        .step_en(st), .flush(fl), .opcode_running(op_run), .uc_counter(ucc),
        .uc_valid(ucv), .busy(busy), .done(done)
    );

    psu_uc_sequencer #(.NUM_UCC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .inst_valid(iv3), .inst_opcode(iop3), .inst_ready(ready3),
        .step_en(st3), .flush(fl3), .opcode_running(op3), .uc_counter(ucc3),
        .uc_valid(ucv3), .busy(busy3), .done(done3)
    );

    // Reference for the default instance: 16 cells, 4 per step, so 4 steps.
    task automatic model_step(input logic v, input logic [3:0] op, input logic s, input logic f);
        if (m_phase == 0) begin
            if (!f && v) begin m_phase = 1; m_k = 0; m_op = op; end
        end else if (m_phase == 1) begin
            if (f) begin m_phase = 0; m_op = 0; end
            else if (s) begin
                if (m_k + 1 == (16 + 4 - 1) / 4) m_phase = 2;
                else m_k = m_k + 1;
            end
        end else begin
            m_phase = 0; m_op = 0;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done); end
        checks++; if (op_run !== 4'h0 || ucc !== 16'h0 || ucv !== 4'h0) begin errors++;
            $display("FAIL reset_data got op=%h cnt=%h val=%b exp 0", op_run, ucc, ucv); end
        checks++; if (ready3 !== 1'b1 || busy3 !== 1'b0 || ucc3 !== 12'h0 || ucv3 !== 3'b0) begin errors++;
            $display("FAIL reset_dut3 got ready=%b busy=%b cnt=%h val=%b", ready3, busy3, ucc3, ucv3); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [15:0] exp_c;
        int npulse;
        @(negedge clk);
        iv = 1; iop = 4'd5; st = 1;
        @(negedge clk);
        iv = 0;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 4; j++) exp_c[j*4 +: 4] = 4'(4*s + j);
            checks++; if (ucc !== exp_c || ucv !== 4'hF) begin errors++;
                $display("FAIL basic_step%0d got cnt=%h val=%b exp cnt=%h val=1111", s, ucc, ucv, exp_c); end
            checks++; if (op_run !== 4'd5 || done !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("FAIL basic_run%0d got op=%h done=%b busy=%b exp 5 0 1", s, op_run, done, busy); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || ucv !== 4'h0 || ucc !== 16'h0) begin errors++;
            $display("FAIL basic_done got done=%b val=%b cnt=%h exp 1 0 0", done, ucv, ucc); end
        st = 0;
        npulse = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) npulse++;
        end
        checks++; if (npulse != 0 || op_run !== 4'h0 || ready !== 1'b1) begin errors++;
            $display("FAIL basic_after got extra_pulses=%0d op=%h ready=%b exp 0 0 1", npulse, op_run, ready); end
    endtask

    task automatic test_ucc3;
        logic [11:0] exp_c;
        @(negedge clk);
        iv3 = 1; iop3 = 4'd9; st3 = 1;
        @(negedge clk);
        iv3 = 0;
        for (int s = 0; s < 6; s++) begin
            if (s < 5) begin
                for (int j = 0; j < 3; j++) exp_c[j*4 +: 4] = 4'(3*s + j);
                checks++; if (ucc3 !== exp_c || ucv3 !== 3'b111 || done3 !== 1'b0) begin errors++;
                    $display("FAIL ucc3_step%0d got cnt=%h val=%b done=%b exp cnt=%h val=111", s, ucc3, ucv3, done3, exp_c); end
            end else begin
                checks++; if (ucc3 !== 12'h00F || ucv3 !== 3'b001) begin errors++;
                    $display("FAIL ucc3_last got cnt=%h val=%b exp cnt=00f val=001", ucc3, ucv3); end
            end
            @(negedge clk);
        end
        checks++; if (done3 !== 1'b1) begin errors++;
            $display("FAIL ucc3_done got done=%b exp 1", done3); end
        st3 = 0;
        @(negedge clk);
    endtask

    task automatic test_stall;
        @(negedge clk);
        iv = 1; iop = 4'd2; st = 1;
        @(negedge clk);
        iv = 0;
        @(negedge clk);
        st = 0; iv = 1; iop = 4'd11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ucc !== 16'h7654 || ucv !== 4'hF || op_run !== 4'd2) begin errors++;
                $display("FAIL stall_hold%0d got cnt=%h val=%b op=%h exp 7654 1111 2", c, ucc, ucv, op_run); end
            checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++;
                $display("FAIL stall_ready%0d got ready=%b busy=%b exp 0 1", c, ready, busy); end
        end
        iv = 0; fl = 1;
        @(negedge clk);
        fl = 0;
    endtask

    task automatic test_flush;
        @(negedge clk);
        iv = 1; iop = 4'd6; st = 1;
        @(negedge clk);
        iv = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ucc !== 16'hBA98) begin errors++;
            $display("FAIL flush_pre got cnt=%h exp ba98", ucc); end
        fl = 1; iv = 1; iop = 4'd3;
        @(negedge clk);
        fl = 0; iv = 0; st = 0;
        checks++; if (busy !== 1'b0 || op_run !== 4'h0 || ready !== 1'b1 || done !== 1'b0 || ucv !== 4'h0) begin errors++;
            $display("FAIL flush_idle got busy=%b op=%h ready=%b done=%b val=%b exp 0 0 1 0 0", busy, op_run, ready, done, ucv); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL flush_nodone got done=%b busy=%b exp 0 0", done, busy); end
        fl = 1; iv = 1; iop = 4'd4;
        @(negedge clk);
        fl = 0; iv = 0;
        checks++; if (busy !== 1'b0 || op_run !== 4'h0) begin errors++;
            $display("FAIL flush_blocks_accept got busy=%b op=%h exp 0 0", busy, op_run); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        iv = 1; iop = 4'd7; st = 1;
        @(negedge clk);
        iv = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || op_run !== 4'h0 || ucc !== 16'h0 || ucv !== 4'h0) begin errors++;
            $display("FAIL async_reset got busy=%b ready=%b done=%b op=%h cnt=%h val=%b", busy, ready, done, op_run, ucc, ucv); end
        st = 0;
        @(negedge clk);
        rst_n = 1; iv = 1; iop = 4'd3;
        @(negedge clk);
        iv = 0;
        checks++; if (busy !== 1'b1 || op_run !== 4'd3 || ucc !== 16'h3210) begin errors++;
            $display("FAIL async_reaccept got busy=%b op=%h cnt=%h exp 1 3 3210", busy, op_run, ucc); end
        fl = 1;
        @(negedge clk);
        fl = 0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        iv = 1; iop = 4'hA; st = 1;
        @(negedge clk);
        iop = 4'hB;
        for (int c = 0; c < 4; c++) @(negedge clk);
        checks++; if (done !== 1'b1 || op_run !== 4'hA) begin errors++;
            $display("FAIL b2b_done got done=%b op=%h exp 1 a", done, op_run); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ready !== 1'b1 || op_run !== 4'h0) begin errors++;
            $display("FAIL b2b_gap got busy=%b ready=%b op=%h exp 0 1 0", busy, ready, op_run); end
        @(negedge clk);
        iv = 0;
        checks++; if (busy !== 1'b1 || op_run !== 4'hB || ucc !== 16'h3210) begin errors++;
            $display("FAIL b2b_second got busy=%b op=%h cnt=%h exp 1 b 3210", busy, op_run, ucc); end
        for (int c = 0; c < 10 && done !== 1'b1; c++) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL b2b_second_done got done=%b exp 1", done); end
        st = 0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [15:0] exp_c;
        logic [3:0]  exp_v;
        logic        v, s, f;
        logic [3:0]  op;
        int          idx;
        m_phase = 0; m_k = 0; m_op = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            exp_c = '0; exp_v = '0;
            if (m_phase == 1) begin
                for (int j = 0; j < 4; j++) begin
                    idx = 4*m_k + j;
                    if (idx < 16) begin exp_v[j] = 1'b1; exp_c[j*4 +: 4] = 4'(idx); end
                end
            end
            checks++; if (ucc !== exp_c || ucv !== exp_v) begin errors++;
                $display("FAIL rand_cnt@%0d got cnt=%h val=%b exp cnt=%h val=%b", i, ucc, ucv, exp_c, exp_v); end
            checks++; if (op_run !== m_op || busy !== (m_phase != 0) || done !== (m_phase == 2) || ready !== (m_phase == 0)) begin errors++;
                $display("FAIL rand_ctrl@%0d got op=%h busy=%b done=%b ready=%b exp op=%h phase=%0d", i, op_run, busy, done, ready, m_op, m_phase); end
            v  = 1'($urandom_range(0, 1));
            op = 4'($urandom);
            s  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 15) == 0);
            iv = v; iop = op; st = s; fl = f;
            model_step(v, op, s, f);
        end
        iv = 0; st = 0; fl = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ucc3;
        test_stall;
        test_flush;
        test_async_reset;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psu_uc_sequencer.md
PSU_UC_SEQUENCER -- requirements
Module: psu_uc_sequencer

Interface
REQ-001 SHALL take parameter OPCODE_BW, default 4: opcode width, equal to `OPCODE_BW.
REQ-002 SHALL take parameter NUM_UCC, default 4: number of unit-cell controllers (UCCs) served in parallel.
REQ-003 SHALL take parameter NUM_UCROW, default 4: unit-cell rows.
REQ-004 SHALL take parameter NUM_UCCOL, default 4: unit-cell columns; TOTAL = NUM_UCROW*NUM_UCCOL.
REQ-005 SHALL take parameter UCADDR_BW, default 4: unit-cell index width, at least clog2(TOTAL).
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port inst_valid, input, 1 bit: an instruction opcode is offered.
REQ-009 SHALL have port inst_opcode, input, OPCODE_BW bits: the offered opcode.
REQ-010 SHALL have port inst_ready, output, 1 bit: the block accepts an instruction this cycle.
REQ-011 SHALL have port step_en, input, 1 bit: downstream PCUs/UCCs finished the current unit-cell step.
REQ-012 SHALL have port flush, input, 1 bit: synchronous abort of the running instruction.
REQ-013 SHALL have port opcode_running, output, OPCODE_BW bits: the opcode fed to the opcode/location decode stage.
REQ-014 SHALL have port uc_counter, output, NUM_UCC*UCADDR_BW bits: the unit-cell index per UCC, with UCC J in slice [J*UCADDR_BW +: UCADDR_BW].
REQ-015 SHALL have port uc_valid, output, NUM_UCC bits: bit J is 1 when UCC J holds an in-range index.
REQ-016 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse marking instruction completion.

Function
REQ-018 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-019 In IDLE, inst_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-020 In IDLE, when inst_valid=1 at a clock edge: opcode_running <= inst_opcode, step index k <= 0, and state <= RUN.
REQ-021 In RUN, UCC J SHALL present index J + k*NUM_UCC; uc_valid[J] = (index < TOTAL); uc_counter slice = index when valid, else 0.
REQ-022 In RUN, on step_en=1: if (k+1)*NUM_UCC >= TOTAL then state <= DONE, else k <= k+1.
REQ-023 The number of steps per instruction SHALL be ceil(TOTAL/NUM_UCC); the index arithmetic SHALL be carried at least clog2(TOTAL+NUM_UCC) bits wide internally so that it never wraps.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle; the state then returns to IDLE and opcode_running <= 0 (NOP).
REQ-025 Outside RUN, uc_valid SHALL be all 0 and uc_counter all 0.
REQ-026 step_en SHALL be ignored in IDLE and DONE; inst_valid SHALL be ignored outside IDLE.
REQ-027 flush=1 in RUN or DONE SHALL force IDLE on the next edge, with opcode_running <= 0 and no done pulse.
REQ-028 flush SHALL take priority over step_en and inst_valid in the same cycle; flush in IDLE SHALL have no effect and SHALL block acceptance in that cycle.
REQ-029 Latency: acceptance at edge t SHALL give a valid opcode_running and uc_counter from cycle t+1; there SHALL be at least one idle cycle (DONE) between back-to-back instructions.
REQ-030 All outputs SHALL be driven from registers or from decode of registered state only, with no combinational path from inputs to outputs except inst_ready, which depends on state only.

Reset
REQ-031 While rst_n=0, regardless of clk: state=IDLE, k=0, opcode_running=0, uc_counter=0, uc_valid=0, busy=0, done=0, inst_ready=1.
REQ-032 When rst_n is asserted mid-RUN, the block SHALL abandon the instruction without a done pulse; the first acceptance is possible at the first edge after rst_n deasserts.

Verification
REQ-033 Defaults, inst_opcode=5 accepted, step_en held at 1 -> uc_counter per UCC {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; uc_valid=4'b1111 on every step; done pulses once, 5 cycles after acceptance.
REQ-034 NUM_UCC=3, TOTAL=16 -> 6 steps; on the final step UCC0=15 with valid, UCC1/UCC2 have uc_valid=0 and counter 0.
REQ-035 step_en stalled 3 cycles mid-RUN -> uc_counter held and no progress; inst_valid during RUN -> no acceptance (inst_ready=0).
REQ-036 flush and step_en both asserted on step 2 -> IDLE next cycle, opcode_running=0, no done pulse, inst_ready=1.
REQ-037 rst_n pulsed low asynchronously mid-RUN -> outputs at reset values immediately, without waiting for a clock edge; a new instruction is then accepted normally.
REQ-038 inst_valid held continuously across two instructions -> second accepted exactly one cycle after the done pulse.
